// File: rtl/decode_stage_pkg.sv
// Shared encodings, control bundle type and ALU-op helper for the decode stage.
package decode_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned OPC_W = 7;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SLTU = 4'd4;
  localparam logic [ALU_W-1:0] ALU_XOR  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd8;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd9;

  localparam logic [SEL_W-1:0] OP1_RS1  = 2'd0;
  localparam logic [SEL_W-1:0] OP1_PC   = 2'd1;
  localparam logic [SEL_W-1:0] OP1_ZERO = 2'd2;

  localparam logic [SEL_W-1:0] WB_ALU = 2'd0;
  localparam logic [SEL_W-1:0] WB_MEM = 2'd1;
  localparam logic [SEL_W-1:0] WB_PC4 = 2'd2;

  localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_IALU   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [ALU_W-1:0] alu_ctrl;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             alu_src;
    logic [SEL_W-1:0] op1_sel;
    logic [SEL_W-1:0] wb_sel;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, OP1_RS1, WB_ALU,
                                 1'b0, 1'b0, 1'b0, 1'b0};

  // funct3 to ALU op; alt selects SUB/SRA variants
  function automatic logic [ALU_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_control_decode.sv
// Combinational RV32I decoder: instruction word to control bundle and immediate.
module control_decode
  import decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output ctrl_t           ctrl,
  output logic [XLEN-1:0] imm
);

  logic [OPC_W-1:0] opc;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [XLEN-1:0]  imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic             is_shift, shift_ok, rtype_ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);
  assign shift_ok = (f7 == 7'b0000000) || ((f3 == 3'b101) && (f7 == 7'b0100000));
  assign rtype_ok = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));

  always_comb begin
    ctrl = CTRL_NOP;
    imm  = '0;
    case (opc)
      OPC_RTYPE: begin
        if (rtype_ok) begin
          ctrl.alu_ctrl  = alu_op(f3, f7[5]);
          ctrl.reg_write = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_IALU: begin
        if (!is_shift || shift_ok) begin
          ctrl.alu_ctrl  = alu_op(f3, (f3 == 3'b101) && f7[5]);
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = is_shift ? imm_sh : imm_i;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (f3 == 3'b010) begin
          ctrl.mem_read  = 1'b1;
          ctrl.wb_sel    = WB_MEM;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          imm            = imm_i;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (f3 == 3'b010) begin
          ctrl.mem_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          imm            = imm_s;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if ((f3 != 3'b010) && (f3 != 3'b011)) begin
          ctrl.is_branch = 1'b1;
          imm            = imm_b;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        ctrl.is_jal    = 1'b1;
        ctrl.wb_sel    = WB_PC4;
        ctrl.reg_write = 1'b1;
        imm            = imm_j;
      end
      OPC_JALR: begin
        if (f3 == 3'b000) begin
          ctrl.is_jalr   = 1'b1;
          ctrl.wb_sel    = WB_PC4;
          ctrl.reg_write = 1'b1;
          ctrl.alu_src   = 1'b1;
          imm            = imm_i;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        ctrl.op1_sel   = (opc == OPC_LUI) ? OP1_ZERO : OP1_PC;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm            = imm_u;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready output register with flush, NOP forcing and retire count.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             flush,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [19:0]      csr,
  output logic [ALU_W-1:0] alu_ctrl,
  output logic [XLEN-1:0]  imm_out,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [SEL_W-1:0] op1_sel,
  output logic [SEL_W-1:0] wb_sel,
  output logic             is_branch,
  output logic             is_jal,
  output logic             is_jalr,
  output logic             illegal,
  output logic [XLEN-1:0]  retired_cnt
);

  ctrl_t           dec_ctrl, ctrl_q;
  logic [XLEN-1:0] dec_imm, instr_q, imm_q;
  logic            accept;

  control_decode u_control_decode (
    .instr (instr),
    .ctrl  (dec_ctrl),
    .imm   (dec_imm)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Raw fields and immediate only change on a real accept; controls fall back to NOP when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      instr_q     <= '0;
      imm_q       <= '0;
      retired_cnt <= '0;
    end else begin
      if (out_valid && out_ready) retired_cnt <= retired_cnt + 32'd1;
      if (flush) begin
        out_valid <= 1'b0;
        ctrl_q    <= CTRL_NOP;
      end else if (accept) begin
        out_valid <= 1'b1;
        ctrl_q    <= dec_ctrl;
        instr_q   <= instr;
        imm_q     <= dec_imm;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        ctrl_q    <= CTRL_NOP;
      end
    end
  end

  assign opcode    = instr_q[6:0];
  assign rd        = instr_q[11:7];
  assign funct3    = instr_q[14:12];
  assign rs1       = instr_q[19:15];
  assign rs2       = instr_q[24:20];
  assign funct7    = instr_q[31:25];
  assign csr       = instr_q[31:12];
  assign imm_out   = imm_q;
  assign alu_ctrl  = ctrl_q.alu_ctrl;
  assign reg_write = ctrl_q.reg_write;
  assign mem_read  = ctrl_q.mem_read;
  assign mem_write = ctrl_q.mem_write;
  assign alu_src   = ctrl_q.alu_src;
  assign op1_sel   = ctrl_q.op1_sel;
  assign wb_sel    = ctrl_q.wb_sel;
  assign is_branch = ctrl_q.is_branch;
  assign is_jal    = ctrl_q.is_jal;
  assign is_jalr   = ctrl_q.is_jalr;
  assign illegal   = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage.
module tb_decode_stage;

  localparam logic [31:0] E_ALU_ADD  = 32'd0;
  localparam logic [31:0] E_ALU_SRA  = 32'd7;
  localparam logic [31:0] E_WB_ALU   = 32'd0;
  localparam logic [31:0] E_WB_MEM   = 32'd1;
  localparam logic [31:0] E_WB_PC4   = 32'd2;
  localparam logic [31:0] E_OP1_ZERO = 32'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic        in_ready, out_valid;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [19:0] csr;
  logic [3:0]  alu_ctrl;
  logic [31:0] imm_out, retired_cnt;
  logic        reg_write, mem_read, mem_write, alu_src;
  logic [1:0]  op1_sel, wb_sel;
  logic        is_branch, is_jal, is_jalr, illegal;

  int n_cmp = 0;
  int n_mis = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
    .csr(csr), .alu_ctrl(alu_ctrl), .imm_out(imm_out), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .op1_sel(op1_sel),
    .wb_sel(wb_sel), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .illegal(illegal), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_retired", retired_cnt, 32'd0);
    check("rst_reg_write", 32'(reg_write), 32'd0);
    check("rst_alu_ctrl", 32'(alu_ctrl), E_ALU_ADD);
    check("rst_imm", imm_out, 32'd0);
    #11;
    reset = 1'b0;

    // ADDI x5,x0,123
    instr = 32'h07B00293; in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_rd", 32'(rd), 32'd5);
    check("addi_rs1", 32'(rs1), 32'd0);
    check("addi_imm", imm_out, 32'd123);
    check("addi_alu", 32'(alu_ctrl), E_ALU_ADD);
    check("addi_alu_src", 32'(alu_src), 32'd1);
    check("addi_reg_write", 32'(reg_write), 32'd1);
    check("addi_wb_sel", 32'(wb_sel), E_WB_ALU);
    check("addi_retired", retired_cnt, 32'd0);

    // SW x5,16(x0)
    instr = 32'h00502823;
    step();
    check("sw_mem_write", 32'(mem_write), 32'd1);
    check("sw_reg_write", 32'(reg_write), 32'd0);
    check("sw_rs2", 32'(rs2), 32'd5);
    check("sw_imm", imm_out, 32'd16);
    check("sw_retired", retired_cnt, 32'd1);

    // BEQ x6,x6,+16
    instr = 32'h00630863;
    step();
    check("beq_branch", 32'(is_branch), 32'd1);
    check("beq_funct3", 32'(funct3), 32'd0);
    check("beq_imm", imm_out, 32'd16);
    check("beq_rs1", 32'(rs1), 32'd6);
    check("beq_reg_write", 32'(reg_write), 32'd0);

    // JAL x1,+40
    instr = 32'h028000EF;
    step();
    check("jal_flag", 32'(is_jal), 32'd1);
    check("jal_rd", 32'(rd), 32'd1);
    check("jal_wb_sel", 32'(wb_sel), E_WB_PC4);
    check("jal_imm", imm_out, 32'd40);
    check("jal_branch", 32'(is_branch), 32'd0);

    // SRAI x13,x12,2
    instr = 32'h40265693;
    step();
    check("srai_alu", 32'(alu_ctrl), E_ALU_SRA);
    check("srai_imm", imm_out, 32'd2);
    check("srai_rd", 32'(rd), 32'd13);
    check("srai_rs1", 32'(rs1), 32'd12);
    check("srai_retired", retired_cnt, 32'd4);

    // backpressure: hold for three cycles with ADDI x1,x0,1 pending
    instr = 32'h00100093; out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready_hold", 32'(in_ready), 32'd0);
      check("bp_alu", 32'(alu_ctrl), E_ALU_SRA);
      check("bp_rd", 32'(rd), 32'd13);
      check("bp_retired", retired_cnt, 32'd4);
    end
    out_ready = 1'b1;
    step();
    check("rel_rd", 32'(rd), 32'd1);
    check("rel_imm", imm_out, 32'd1);
    check("rel_retired", retired_cnt, 32'd5);

    // flush in the same cycle as an ADDI accept
    instr = 32'h07B00293; flush = 1'b1;
    step();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_reg_write", 32'(reg_write), 32'd0);
    check("flush_rd_kept", 32'(rd), 32'd1);
    check("flush_retired", retired_cnt, 32'd6);
    check("flush_in_ready", 32'(in_ready), 32'd1);

    // all-ones word is illegal
    flush = 1'b0; instr = 32'hFFFFFFFF;
    step();
    check("ill_valid", 32'(out_valid), 32'd1);
    check("ill_flag", 32'(illegal), 32'd1);
    check("ill_opcode", 32'(opcode), 32'h7F);
    check("ill_side_fx", {26'b0, reg_write, mem_read, mem_write, is_branch, is_jal, is_jalr}, 32'd0);
    check("ill_retired", retired_cnt, 32'd6);

    // load with unsupported funct3
    instr = 32'h00001003;
    step();
    check("lwf3_illegal", 32'(illegal), 32'd1);
    check("lwf3_mem_read", 32'(mem_read), 32'd0);
    check("lwf3_retired", retired_cnt, 32'd7);

    // idle cycle drains to NOP
    in_valid = 1'b0;
    step();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_illegal", 32'(illegal), 32'd0);
    check("idle_retired", retired_cnt, 32'd8);

    // LUI x5,0x12345
    in_valid = 1'b1; instr = 32'h123452B7;
    step();
    check("lui_imm", imm_out, 32'h12345000);
    check("lui_op1", 32'(op1_sel), E_OP1_ZERO);
    check("lui_alu_src", 32'(alu_src), 32'd1);
    check("lui_csr", 32'(csr), 32'h12345);

    // LW x2,0(x1)
    instr = 32'h0000A103;
    step();
    check("lw_mem_read", 32'(mem_read), 32'd1);
    check("lw_wb_sel", 32'(wb_sel), E_WB_MEM);
    check("lw_rd", 32'(rd), 32'd2);
    check("lw_retired", retired_cnt, 32'd9);

    // asynchronous reset between edges while holding a bundle
    out_ready = 1'b0; in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_retired", retired_cnt, 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_mem_read", 32'(mem_read), 32'd0);
    check("arst_rd", 32'(rd), 32'd0);
    check("arst_imm", imm_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage between instruction fetch and the `datapath` control inputs. Accepts a 32-bit RV32I instruction word over a valid/ready handshake and decodes it into the full control bundle the datapath consumes. It holds that bundle in a single output register with backpressure and flush. Whenever no valid instruction is presented, the outputs carry a side-effect-free NOP bundle.

## Interface
- No parameters; all encodings come from `defines.vh`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instr` in 32: instruction word from fetch.
- `in_valid` in 1: `instr` is valid this cycle.
- `in_ready` out 1: stage can accept this cycle.
- `out_valid` out 1: the output bundle holds a decoded instruction.
- `out_ready` in 1: the datapath consumes the bundle this cycle.
- `flush` in 1: kill the held instruction and any instruction accepted this cycle (taken branch, jump, or redirect).
- `opcode` out 7, `rd` out 5, `funct3` out 3, `rs1` out 5, `rs2` out 5, `funct7` out 7: raw instruction fields.
- `csr` out 20: `instr[31:12]`.
- `alu_ctrl` out 4: ALU operation.
- `imm_out` out 32: sign-extended immediate.
- `reg_write`, `mem_read`, `mem_write`, `alu_src` out 1 each: datapath controls.
- `op1_sel` out 2, `wb_sel` out 2: operand-1 and writeback selects.
- `is_branch`, `is_jal`, `is_jalr` out 1 each: control-flow flags.
- `illegal` out 1: the held instruction is an unsupported encoding.
- `retired_cnt` out 32: count of bundles consumed (`out_valid && out_ready`).

## Operation
- Decode table:
  - R-type `0110011` (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND): `alu_src=0`, `reg_write=1`, `wb_sel=WB_ALU`, `op1_sel=OP1_RS1`.
  - I-ALU `0010011`: same as R-type except `alu_src=1`. Shifts use `imm_out={27'b0,instr[24:20]}`, and SRAI is selected by `funct7[5]`. ADDI never maps to SUB.
  - LOAD `0000011`, `funct3=010` only: `mem_read=1`, `wb_sel=WB_MEM`, `alu_src=1`, `ALU_ADD`, `reg_write=1`.
  - STORE `0100011`, `funct3=010` only: `mem_write=1`, `alu_src=1`, `ALU_ADD`, S-immediate.
  - BRANCH `1100011`, funct3 in {000,001,100,101,110,111}: `is_branch=1`, B-immediate.
  - JAL `1101111`: `is_jal=1`, `wb_sel=WB_PC4`, `reg_write=1`, J-immediate.
  - JALR `1100111`, `funct3=000`: `is_jalr=1`, `wb_sel=WB_PC4`, `reg_write=1`, `alu_src=1`, I-immediate.
  - LUI `0110111`: `op1_sel=OP1_ZERO`, `alu_src=1`, `ALU_ADD`, U-immediate.
  - AUIPC `0010111`: `op1_sel=OP1_PC`, otherwise the same as LUI.
- Any other encoding, including an unsupported funct3, sets `illegal=1`, forces all side-effect controls to 0, and still sets `out_valid=1`.
- `rd` is passed through unchanged. Writes to x0 are the register file's responsibility.
- When `out_valid=0`, the outputs present the NOP bundle:
  - `reg_write`, `mem_read`, `mem_write`, `is_branch`, `is_jal`, `is_jalr`, `illegal` are all 0.
  - `alu_ctrl=ALU_ADD`, `op1_sel=OP1_RS1`, `wb_sel=WB_ALU`.
  - The raw fields keep their last value.
- `retired_cnt` wraps modulo 2^32.

## Timing
- `in_ready = !out_valid || out_ready`. This is combinational; `flush` does not affect it.
- Accept condition: `in_valid && in_ready`. The decoded bundle appears on the next rising edge with `out_valid=1`, giving a latency of 1 cycle.
- Back-to-back accepts while `out_ready=1` give a throughput of 1 instruction per cycle.
- While `out_valid && !out_ready`, every output holds stable and no instruction is accepted.
- `flush` has priority:
  - The next state is `out_valid=0` with the NOP bundle.
  - An instruction accepted in the same cycle is discarded.
  - A bundle consumed in the same cycle still counts in `retired_cnt`.
- Asynchronous `reset` produces the following immediately, including mid-handshake:
  - `out_valid=0` and the NOP bundle.
  - All raw fields, `imm_out`, `csr` and `retired_cnt` set to 0.
  - `in_ready=1`.

## Structure
- `defines.vh` holds:
  - the `ALU_*`, `OP1_RS1/OP1_PC/OP1_ZERO` and `WB_ALU/WB_MEM/WB_PC4` encodings;
  - opcode constants `OPC_RTYPE`, `OPC_IALU`, `OPC_LOAD`, `OPC_STORE`, `OPC_BRANCH`, `OPC_JAL`, `OPC_JALR`, `OPC_LUI`, `OPC_AUIPC`.
  - Any of these not already present is added there.
- One combinational sub-module, `control_decode` (instr → control bundle + `illegal`), with immediate generation inside it. `decode_stage` contains the handshake register, flush and reset logic, NOP forcing, and the counter.

## Test plan
- ADDI x5,x0,123: `0x07B00293` accepted, `out_ready=1` → next cycle `out_valid=1`, `rd=5`, `rs1=0`, `imm_out=123`, `alu_ctrl=ALU_ADD`, `alu_src=1`, `reg_write=1`, `wb_sel=WB_ALU`.
- SW x5,16(x0) `0x00502823` → `mem_write=1`, `reg_write=0`, `rs2=5`, `imm_out=16`. Then BEQ x6,x6,+16 `0x00630863` → `is_branch=1`, `funct3=000`, `imm_out=16`.
- JAL x1,+40 `0x028000EF` → `is_jal=1`, `rd=1`, `wb_sel=WB_PC4`, `imm_out=40`. SRAI x13,x12,2 `0x40265693` → `alu_ctrl=ALU_SRA`, `imm_out=2`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, the bundle is unchanged, and `retired_cnt` does not increment. Releasing `out_ready` → next instruction accepted and `retired_cnt` increments by 1.
- `flush` asserted in the same cycle as an ADDI accept → next cycle `out_valid=0`, `reg_write=0`. `0xFFFFFFFF` → `illegal=1`, `out_valid=1`, all side-effect controls 0.
- Assert `reset` asynchronously between clock edges while `out_valid=1` → `out_valid=0`, `retired_cnt=0`, and `in_ready=1` before the next clock edge.
